ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_slave.sv | 182 ++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a word-addressed on-chip SRAM.
// Supports programmable wait states, the two-cycle ERROR response and read-after-write forwarding.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        AHB_sel,
    input  logic [31:0] AHB_haddr,
    input  logic [1:0]  AHB_htrans,
    input  logic        AHB_hwrite,
    input  logic [2:0]  AHB_hsize,
    input  logic [2:0]  AHB_hburst,
    input  logic [3:0]  AHB_hprot,
    input  logic [31:0] AHB_hwdata,
    input  logic        AHB_hready_in,
    output logic        AHB_hready_out,
    output logic        AHB_hresp,
    output logic [31:0] AHB_hrdata
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_ERR1 = 2'd2;
    localparam logic [1:0]  S_ERR2 = 2'd3;
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WS_L   = WAIT_STATES[3:0];

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] ofs);
        logic [3:0] be;
        case (size)
            3'b000:  be = 4'b0001 << ofs;
            3'b001:  be = ofs[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]           mem_r [DEPTH];
    logic [1:0]            state_r, state_nx_s;
    logic [3:0]            cnt_r, cnt_nx_s;
    logic                  hready_out_r, hresp_r, hready_nx_s, hresp_nx_s;
    logic [31:0]           hrdata_r;
    logic                  dp_valid_r, dp_write_r;
    logic [ADDR_WIDTH-1:0] dp_addr_r, acc_word_s, rd_addr_s;
    logic [3:0]            dp_be_r;
    logic                  accept_s, legal_s, in_range_s, size_ok_s, aligned_s;
    logic                  wr_en_s, rd_load_s;
    logic [31:0]           rd_word_s, rd_data_s;
    logic                  unused_s;

    assign unused_s   = ^{AHB_hburst, AHB_hprot, AHB_htrans[0]};
    assign acc_word_s = AHB_haddr[ADDR_WIDTH+1:2];
    assign in_range_s = (AHB_haddr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign size_ok_s  = (AHB_hsize <= 3'b010);
    assign legal_s    = in_range_s & size_ok_s & aligned_s;
    // A new address phase is only taken while our own data phase is not stalling.
    assign accept_s   = AHB_sel & AHB_hready_in & AHB_htrans[1] & hready_out_r;
    assign wr_en_s    = dp_valid_r & dp_write_r & hready_out_r;

    // Alignment check of the address-phase transfer size.
    always_comb begin
        aligned_s = 1'b1;
        case (AHB_hsize)
            3'b001:  aligned_s = ~AHB_haddr[0];
            3'b010:  aligned_s = (AHB_haddr[1:0] == 2'b00);
            default: aligned_s = 1'b1;
        endcase
    end

    // Next-state and wait counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            S_IDLE, S_ERR2: begin
                if (accept_s) begin
                    if (!legal_s) begin
                        state_nx_s = S_ERR1;
                    end else if (WS_L == 4'd0) begin
                        state_nx_s = S_IDLE;
                    end else begin
                        state_nx_s = S_WAIT;
                        cnt_nx_s   = WS_L;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nx_s = S_IDLE;
                    cnt_nx_s   = 4'd0;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            S_ERR1:  state_nx_s = S_ERR2;
            default: state_nx_s = S_IDLE;
        endcase
        hready_nx_s = (state_nx_s == S_IDLE) || (state_nx_s == S_ERR2);
        hresp_nx_s  = (state_nx_s == S_ERR1) || (state_nx_s == S_ERR2);
    end

    // Read port: load hrdata at the edge that opens the completing cycle; forward a same-edge write.
    always_comb begin
        if (WS_L == 4'd0) begin
            rd_load_s = accept_s & legal_s & ~AHB_hwrite;
        end else begin
            rd_load_s = (state_r == S_WAIT) & (cnt_r == 4'd1) & ~dp_write_r;
        end
        if (state_r == S_WAIT) begin
            rd_addr_s = dp_addr_r;
        end else begin
            rd_addr_s = acc_word_s;
        end
        rd_word_s = mem_r[rd_addr_s];
        if (wr_en_s && (dp_addr_r == rd_addr_s)) begin
            rd_data_s = merge_bytes(rd_word_s, AHB_hwdata, dp_be_r);
        end else begin
            rd_data_s = rd_word_s;
        end
    end

    // Control state, pending data-phase record and registered bus outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= S_IDLE;
            cnt_r        <= 4'd0;
            hready_out_r <= 1'b1;
            hresp_r      <= 1'b0;
            hrdata_r     <= 32'h0000_0000;
            dp_valid_r   <= 1'b0;
            dp_write_r   <= 1'b0;
            dp_addr_r    <= '0;
            dp_be_r      <= 4'b0000;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            hready_out_r <= hready_nx_s;
            hresp_r      <= hresp_nx_s;
            if (rd_load_s) begin
                hrdata_r <= rd_data_s;
            end
            if (hready_out_r) begin
                dp_valid_r <= accept_s & legal_s;
                if (accept_s) begin
                    dp_write_r <= AHB_hwrite;
                    dp_addr_r  <= acc_word_s;
                    dp_be_r    <= byte_en(AHB_hsize, AHB_haddr[1:0]);
                end
            end
        end
    end

    // SRAM byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be_r[i]) begin
                    mem_r[dp_addr_r][8*i +: 8] <= AHB_hwdata[8*i +: 8];
                end
            end
        end
    end

    assign AHB_hready_out = hready_out_r;
    assign AHB_hresp      = hresp_r;
    assign AHB_hrdata     = hrdata_r;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a zero-wait and a two-wait instance driven by a
// table of AHB beats plus hand sequences for reset during a data phase.
module tb_ahb_sram_slave;

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef struct packed {
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        sel0, sel1, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        rdy0, resp0, rdy1, resp1;
    logic [31:0] rd0, rd1;

    beat_t tbl [0:127];
    int    nb = 0;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .nrst(nrst), .AHB_sel(sel0), .AHB_haddr(haddr), .AHB_htrans(htrans),
        .AHB_hwrite(hwrite), .AHB_hsize(hsize), .AHB_hburst(hburst), .AHB_hprot(hprot),
        .AHB_hwdata(hwdata), .AHB_hready_in(rdy0), .AHB_hready_out(rdy0),
        .AHB_hresp(resp0), .AHB_hrdata(rd0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .nrst(nrst), .AHB_sel(sel1), .AHB_haddr(haddr), .AHB_htrans(htrans),
        .AHB_hwrite(hwrite), .AHB_hsize(hsize), .AHB_hburst(hburst), .AHB_hprot(hprot),
        .AHB_hwdata(hwdata), .AHB_hready_in(rdy1), .AHB_hready_out(rdy1),
        .AHB_hresp(resp1), .AHB_hrdata(rd1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] t, input logic w, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input logic e, input logic c, input logic [31:0] rd);
        tbl[nb] = '{t, w, s, a, wd, e, c, rd};
        nb++;
    endtask

    // Pipelined AHB master over tbl[first +: n]; checks every cycle of every data phase.
    task automatic run(input int which, input int first, input int n, input int ws, output int cycles);
        int k, drv, dp, stall, cyc, exp_st;
        logic h, hp, r;
        logic [31:0] d;
        bit tmo;
        k = 0; drv = -1; dp = -1; stall = 0; cyc = 0; hp = 1'b1; tmo = 1'b0;
        sel0 = (which == 0);
        sel1 = (which == 1);
        while ((k < n || drv >= 0 || dp >= 0) && !tmo) begin
            cyc++;
            h = (which == 1) ? rdy1 : rdy0;
            r = (which == 1) ? resp1 : resp0;
            d = (which == 1) ? rd1 : rd0;
            if (hp) begin
                if (drv >= 0) begin
                    k  = drv + 1;
                    dp = tbl[first+drv].trans[1] ? drv : -1;
                end else begin
                    dp = -1;
                end
                stall = 0;
            end
            hwdata = (dp >= 0) ? tbl[first+dp].wdata : 32'hFFFF_FFFF;
            if (k < n) begin
                htrans = tbl[first+k].trans;
                hwrite = tbl[first+k].wr;
                hsize  = tbl[first+k].size;
                haddr  = tbl[first+k].addr;
                drv    = k;
            end else begin
                htrans = 2'b00;
                hwrite = 1'b0;
                drv    = -1;
            end
            if (dp >= 0) begin
                chk($sformatf("hresp[dut%0d beat %0d]", which, first+dp), 32'(r), 32'(tbl[first+dp].err));
                if (!h) begin
                    stall++;
                end else begin
                    exp_st = tbl[first+dp].err ? 1 : ws;
                    chk($sformatf("wait_cycles[dut%0d beat %0d]", which, first+dp), 32'(stall), 32'(exp_st));
                    if (tbl[first+dp].chk) begin
                        chk($sformatf("hrdata[dut%0d beat %0d]", which, first+dp), d, tbl[first+dp].rdata);
                    end
                    dp = -1;
                end
            end else begin
                chk($sformatf("idle_ready[dut%0d]", which), 32'(h), 32'd1);
                chk($sformatf("idle_resp[dut%0d]", which), 32'(r), 32'd0);
            end
            hp = h;
            if (cyc > 300) begin
                chk("run_timeout", 32'(cyc), 32'd300);
                tmo = 1'b1;
            end
            @(posedge clk); #1;
        end
        cycles = cyc;
        htrans = 2'b00;
        sel0   = 1'b0;
        sel1   = 1'b0;
    endtask

    initial begin
        int s1, s2, s3, s4, s5, sr1, sr2, cyc;
        nrst = 1'b0; sel0 = 1'b0; sel1 = 1'b0; haddr = 32'h0; hwdata = 32'h0;
        htrans = 2'b00; hwrite = 1'b0; hsize = SW; hburst = 3'b000; hprot = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready0", 32'(rdy0), 32'd1);
        chk("reset_resp0", 32'(resp0), 32'd0);
        chk("reset_rdata0", rd0, 32'h0);
        chk("reset_ready2", 32'(rdy1), 32'd1);
        chk("reset_rdata2", rd1, 32'h0);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Single, sub-word and forwarding vectors.
        s1 = nb;
        add(NS, 1'b1, SW, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b0, SW, 32'h10, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF);
        add(NS, 1'b1, SW, 32'h20, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b1, SB, 32'h21, 32'hFFFF_AAFF, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b1, SH, 32'h22, 32'hBBCC_FFFF, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b0, SW, 32'h20, 32'h0,         1'b0, 1'b1, 32'hBBCC_AA44);
        add(NS, 1'b0, SB, 32'h23, 32'h0,         1'b0, 1'b1, 32'hBBCC_AA44);
        add(NS, 1'b1, SW, 32'h30, 32'h5566_7788, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b0, SW, 32'h30, 32'h0,         1'b0, 1'b1, 32'h5566_7788);
        add(NS, 1'b1, SB, 32'h31, 32'h0000_EE00, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b0, SW, 32'h30, 32'h0,         1'b0, 1'b1, 32'h5566_EE88);
        add(NS, 1'b1, SH, 32'h30, 32'hFFFF_1234, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b0, SW, 32'h30, 32'h0,         1'b0, 1'b1, 32'h5566_1234);
        // INCR16 preload and read-back.
        s2 = nb;
        for (int i = 0; i < 16; i++) add((i == 0) ? NS : SQ, 1'b1, SW, 32'h40 + 32'(4*i), 32'(i), 1'b0, 1'b0, 32'h0);
        s3 = nb;
        for (int i = 0; i < 16; i++) add((i == 0) ? NS : SQ, 1'b0, SW, 32'h40 + 32'(4*i), 32'h0, 1'b0, 1'b1, 32'(i));
        // BUSY beats inside a burst, one of them flagged as a write.
        s4 = nb;
        add(NS, 1'b0, SW, 32'h40, 32'h0, 1'b0, 1'b1, 32'd0);
        add(BZ, 1'b1, SW, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0);
        add(SQ, 1'b0, SW, 32'h44, 32'h0, 1'b0, 1'b1, 32'd1);
        add(BZ, 1'b0, SW, 32'h48, 32'h0, 1'b0, 1'b0, 32'h0);
        add(SQ, 1'b0, SW, 32'h48, 32'h0, 1'b0, 1'b1, 32'd2);
        // Illegal accesses: out of window, misaligned word/half, oversize.
        s5 = nb;
        add(NS, 1'b1, SW, 32'h00,   32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b0, SW, 32'h4000, 32'h0,         1'b1, 1'b0, 32'h0);
        add(NS, 1'b1, SW, 32'h02,   32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        add(NS, 1'b0, 3'b011, 32'h00, 32'h0,       1'b1, 1'b0, 32'h0);
        add(NS, 1'b1, SH, 32'h01,   32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        add(NS, 1'b0, SW, 32'h00,   32'h0,         1'b0, 1'b1, 32'h0BAD_F00D);
        sr1 = nb;
        add(NS, 1'b1, SW, 32'h80, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        add(NS, 1'b0, SW, 32'h80, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D);
        sr2 = nb;
        add(NS, 1'b0, SW, 32'h80, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D);

        run(0, s1, s2 - s1, 0, cyc);
        run(1, s1, s2 - s1, 2, cyc);
        hburst = 3'b111;
        run(0, s2, 16, 0, cyc);
        run(1, s2, 16, 2, cyc);
        run(0, s3, 16, 0, cyc);
        chk("incr16_cycles_ws0", 32'(cyc), 32'd17);
        run(1, s3, 16, 2, cyc);
        chk("incr16_cycles_ws2", 32'(cyc), 32'd49);
        run(0, s4, s5 - s4, 0, cyc);
        run(1, s4, s5 - s4, 2, cyc);
        hburst = 3'b000;
        run(0, s5, sr1 - s5, 0, cyc);
        run(1, s5, sr1 - s5, 2, cyc);
        run(0, sr1, sr2 - sr1, 0, cyc);

        // Reset while a write to 0x80 sits in its data phase.
        sel0 = 1'b1; htrans = NS; hwrite = 1'b1; hsize = SW; haddr = 32'h80; hburst = 3'b111;
        @(posedge clk); #1;
        hwdata = 32'h1234_5678; htrans = SQ; haddr = 32'h84;
        #2 nrst = 1'b0;
        #1;
        chk("midreset_ready", 32'(rdy0), 32'd1);
        chk("midreset_resp", 32'(resp0), 32'd0);
        chk("midreset_rdata", rd0, 32'h0);
        chk("midreset_rdata2", rd1, 32'h0);
        htrans = 2'b00; hwrite = 1'b0; sel0 = 1'b0;
        @(posedge clk); #1;
        chk("inreset_ready", 32'(rdy0), 32'd1);
        nrst = 1'b1;
        @(posedge clk); #1;
        run(0, sr2, 1, 0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
